// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the execute-stage ALU: default datapath width and the
// 4-bit function-select codes driven by the upstream control decode.
// Build option: ALU_OVERFLOW_EN (consumed by alu.sv, not by this package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_ADDU = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SUBU = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // Ops that run the shared adder in subtract mode.
    function automatic logic is_sub_op(input logic [3:0] func);
        return (func == ALU_SUB) || (func == ALU_SUBU) ||
               (func == ALU_SLT) || (func == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// ---------------------------------------------------------------------------
// alu_addsub
// Single shared adder: sum = a + (sub ? ~b : b) + sub.
// Ports:
//   a, b   in   WIDTH  operands
//   sub    in   1      1 = subtract (two's complement of b)
//   sum    out  WIDTH  result, wraps modulo 2^WIDTH
//   carry  out  1      carry-out; in subtract mode its inverse is the borrow
//   ovf    out  1      signed overflow of the operation actually performed
// ---------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];

    // Overflow: both addends share a sign and the sum's sign differs from it.
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// 32-bit integer ALU for the MIPS execute stage. Result and zero flag are
// registered one clock after the operands are sampled; a new op is accepted
// every cycle.
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset
//   In1     in   WIDTH  operand A (rs)
//   In2     in   WIDTH  operand B (rt or extended immediate)
//   Func    in   4      operation select (codes in alu_pkg)
//   ALUout  out  WIDTH  registered result
//   zero    out  1      registered, 1 when ALUout is all zeros
//   ovf     out  1      registered signed overflow of add/sub
//                       (present only when ALU_OVERFLOW_EN is defined)
// Build option: ALU_OVERFLOW_EN adds the ovf port and register.
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [3:0]       Func,
    output logic [WIDTH-1:0] ALUout,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    logic             sub_mode;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             slt_bit;
    logic             sltu_bit;
    logic [WIDTH-1:0] result_next;

    assign sub_mode = is_sub_op(Func);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (In1),
        .b     (In2),
        .sub   (sub_mode),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    // Signed less-than is N xor V so it stays correct when In1 - In2 overflows.
    assign slt_bit  = as_sum[WIDTH-1] ^ as_ovf;
    // Unsigned less-than is the borrow, i.e. no carry out of In1 + ~In2 + 1.
    assign sltu_bit = ~as_carry;

    always_comb begin
        result_next = '0;
        case (Func)
            ALU_AND:  result_next = In1 & In2;
            ALU_OR:   result_next = In1 | In2;
            ALU_XOR:  result_next = In1 ^ In2;
            ALU_ADD,
            ALU_ADDU,
            ALU_SUB,
            ALU_SUBU: result_next = as_sum;
            ALU_LUI:  result_next = In2 << (WIDTH / 2);
            ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, sltu_bit};
            default:  result_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUout <= '0;
            zero   <= 1'b1;
        end else begin
            ALUout <= result_next;
            zero   <= (result_next == '0);
        end
    end

`ifdef ALU_OVERFLOW_EN
    // Only the trapping-style opcodes report overflow; addu/subu never do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ((Func == ALU_ADD) || (Func == ALU_SUB)) && as_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [3:0]  Func;
    logic [31:0] ALUout;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .In1    (In1),
        .In2    (In2),
        .Func   (Func),
        .ALUout (ALUout),
        .zero   (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Drive one op, let it be registered, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        In1  = a;
        In2  = b;
        Func = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        In1  = 32'd5;
        In2  = 32'd3;
        Func = 4'b0010;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ALUout !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_async_result: got %h want %h", ALUout, 32'h0);
        end
        n_cmp++;
        if (zero !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_async_zero: got %b want 1", zero);
        end
`ifdef ALU_OVERFLOW_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_ovf: got %b want 0", ovf);
        end
`endif
        @(posedge clk);
        #1;
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_held: got %h/%b want 00000000/1", ALUout, zero);
        end
        rst = 1'b0;
        step(32'd2, 32'd1, 4'b0000);
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL first_and: got %h/%b want 00000000/1", ALUout, zero);
        end
    endtask

    task automatic test_sweep();
        logic [3:0]  funcs [9];
        logic [31:0] exps  [9];
        funcs = '{4'b0010, 4'b1010, 4'b0001, 4'b0100, 4'b0110,
                  4'b1110, 4'b1011, 4'b1111, 4'b0101};
        exps  = '{32'd3, 32'd1, 32'd3, 32'd3, 32'd3,
                  32'd1, 32'd0, 32'd0, 32'h0001_0000};
        for (int i = 0; i < 9; i++) begin
            step(32'd2, 32'd1, funcs[i]);
            n_cmp++;
            if (ALUout !== exps[i] || zero !== (exps[i] == 32'h0)) begin
                n_bad++;
                $display("FAIL sweep_func_%b: got %h/%b want %h/%b",
                         funcs[i], ALUout, zero, exps[i], exps[i] == 32'h0);
            end
        end
    endtask

    task automatic test_logic_lui();
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [3:0]  fs  [4];
        logic [31:0] exs [4];
        as  = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
        bs  = '{32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0001_ABCD};
        fs  = '{4'b0000, 4'b0001, 4'b0100, 4'b0101};
        exs = '{32'hF000_F000, 32'hFFFF_FFFF, 32'h5555_5555, 32'hABCD_0000};
        for (int i = 0; i < 4; i++) begin
            step(as[i], bs[i], fs[i]);
            n_cmp++;
            if (ALUout !== exs[i] || zero !== 1'b0) begin
                n_bad++;
                $display("FAIL logic_func_%b: got %h/%b want %h/0",
                         fs[i], ALUout, zero, exs[i]);
            end
        end
    endtask

    task automatic test_wrap();
        step(32'hFFFF_FFFF, 32'd1, 4'b0010);
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL add_wrap: got %h/%b want 00000000/1", ALUout, zero);
        end
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010);
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_equal: got %h/%b want 00000000/1", ALUout, zero);
        end
        step(32'd3, 32'd5, 4'b1110);
        n_cmp++;
        if (ALUout !== 32'hFFFF_FFFE || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL subu_wrap: got %h/%b want fffffffe/0", ALUout, zero);
        end
    endtask

    task automatic test_compare();
        logic [31:0] as  [8];
        logic [31:0] bs  [8];
        logic [3:0]  fs  [8];
        logic [31:0] exs [8];
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                32'd1,         32'd1,         32'h8000_0000, 32'h7FFF_FFFF};
        bs  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'h8000_0000};
        fs  = '{4'b1011, 4'b1111, 4'b1011, 4'b1111,
                4'b1011, 4'b1111, 4'b1011, 4'b1011};
        exs = '{32'd0, 32'd0, 32'd1, 32'd1,
                32'd0, 32'd1, 32'd1, 32'd0};
        for (int i = 0; i < 8; i++) begin
            step(as[i], bs[i], fs[i]);
            n_cmp++;
            if (ALUout !== exs[i] || zero !== (exs[i] == 32'h0)) begin
                n_bad++;
                $display("FAIL compare_%0d_func_%b: got %h/%b want %h", i, fs[i],
                         ALUout, zero, exs[i]);
            end
        end
    endtask

    task automatic test_undefined();
        logic [3:0] fs [6];
        fs = '{4'b1101, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1100};
        for (int i = 0; i < 6; i++) begin
            // Precede each with a nonzero result so a stuck register is visible.
            step(32'd2, 32'd1, 4'b0010);
            step(32'h8000_0000, 32'd1, fs[i]);
            n_cmp++;
            if (ALUout !== 32'h0 || zero !== 1'b1) begin
                n_bad++;
                $display("FAIL undefined_func_%b: got %h/%b want 00000000/1",
                         fs[i], ALUout, zero);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(32'd5, 32'd5, 4'b1010);
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_sub: got %h/%b want 00000000/1", ALUout, zero);
        end
        step(32'd5, 32'd5, 4'b0010);
        n_cmp++;
        if (ALUout !== 32'd10 || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_add: got %h/%b want 0000000a/0", ALUout, zero);
        end
        step(32'd0, 32'd0, 4'b0001);
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_or: got %h/%b want 00000000/1", ALUout, zero);
        end
    endtask

    task automatic test_midstream_reset();
        step(32'h7FFF_FFFF, 32'd1, 4'b0010);
        n_cmp++;
        if (ALUout !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL pre_reset_add: got %h want 80000000", ALUout);
        end
`ifdef ALU_OVERFLOW_EN
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_ovf: got %b want 1", ovf);
        end
`endif
        In1  = 32'd1;
        In2  = 32'd1;
        Func = 4'b0010;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ALUout !== 32'h0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_result: got %h/%b want 00000000/1", ALUout, zero);
        end
`ifdef ALU_OVERFLOW_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ALUout !== 32'd2 || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_add: got %h/%b want 00000002/0", ALUout, zero);
        end
    endtask

`ifdef ALU_OVERFLOW_EN
    task automatic test_ovf();
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [3:0]  fs  [6];
        logic [31:0] exs [6];
        logic        eov [6];
        as  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                32'd1,         32'h8000_0000};
        bs  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        fs  = '{4'b0010, 4'b0110, 4'b1010, 4'b1110, 4'b0010, 4'b1011};
        exs = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                32'd2,         32'd1};
        eov = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(as[i], bs[i], fs[i]);
            n_cmp++;
            if (ALUout !== exs[i] || ovf !== eov[i]) begin
                n_bad++;
                $display("FAIL ovf_%0d_func_%b: got %h/ovf=%b want %h/ovf=%b", i, fs[i],
                         ALUout, ovf, exs[i], eov[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_logic_lui();
        test_wrap();
        test_compare();
        test_undefined();
        test_back_to_back();
`ifdef ALU_OVERFLOW_EN
        test_ovf();
`endif
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
